// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with programmable wait states.
// Define DMEM_RESP_ERR_EN to flag misaligned / out-of-segment accesses.
module dmem_responder #(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h10010000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH];
  logic [AW-1:0] idx;
  logic          bad;
  logic          commit;

  // Power-of-two DEPTH: truncation of the word offset gives the wrap.
  assign idx = AW'((addr_q - BASE_ADDR) >> 2);

`ifdef DMEM_RESP_ERR_EN
  localparam logic [32:0] END_ADDR =
    {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

  assign bad = (addr_q[1:0] != 2'b00) ||
               (addr_q < BASE_ADDR) ||
               ({1'b0, addr_q} >= END_ADDR);
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    commit      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          be_d        = req_be;
          cnt_d       = 8'd0;
          req_ready_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 8'(WAIT_CYCLES)) begin
          commit      = 1'b1;
          rsp_valid_d = 1'b1;
          err_d       = bad;
          if (bad)
            rdata_d = 32'hDEADBEEF;
          else if (we_q)
            rdata_d = 32'd0;
          else
            rdata_d = mem_q[idx];
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= 32'd0;
    end else if (commit && we_q && !bad) begin
      for (int b = 0; b < 4; b++)
        if (be_q[b])
          mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
